// File: rtl/uart_matrix_formatter.sv
// uart_matrix_formatter: streams a rows x cols matrix of elements to a
// byte-wide UART as ASCII hex or raw bytes. Columns are separated by
// SEP_CHAR and each row ends with CR LF.
module uart_matrix_formatter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIM_W    = 8,
    parameter logic [7:0]  SEP_CHAR = 8'h20
) (
    input  logic                 system_clock,
    input  logic                 rst_n,
    input  logic                 clock_enable,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode_hex,
    input  logic [DIM_W-1:0]     num_rows,
    input  logic [DIM_W-1:0]     num_cols,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 data_valid,
    output logic                 data_req,
    input  logic                 busy_uart,
    output logic                 start_uart,
    output logic [7:0]           urt_tx_data,
    output logic                 busy,
    output logic                 done,
    output logic [2*DIM_W-1:0]   elem_count
);

    localparam int unsigned NIBBLES = DATA_W / 4;
    localparam int unsigned BYTES   = DATA_W / 8;
    localparam logic [3:0]  HEX_LEN = 4'(NIBBLES);
    localparam logic [3:0]  RAW_LEN = 4'(BYTES);

    localparam logic [DIM_W-1:0]   DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [2*DIM_W-1:0] COUNT_ONE = {{(2*DIM_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        KICK,
        WAIT_TX,
        NEXT
    } state_t;

    state_t            state;
    logic              cfg_hex;
    logic [DIM_W-1:0]  cfg_rows;
    logic [DIM_W-1:0]  cfg_cols;
    logic [DIM_W-1:0]  row_idx;
    logic [DIM_W-1:0]  col_idx;
    logic [3:0]        char_idx;
    logic [DATA_W-1:0] elem_reg;

    logic [3:0]        elem_len;
    logic [3:0]        seq_len;
    logic [3:0]        pos;
    logic              last_col;
    logic              last_row;
    logic [3:0]        nibble;
    logic [7:0]        byte_sel;
    logic [7:0]        cur_char;

    // Element/suffix geometry derived from the latched configuration and indices
    always_comb begin
        elem_len = cfg_hex ? HEX_LEN : RAW_LEN;
        last_col = (col_idx == cfg_cols - DIM_ONE);
        last_row = (row_idx == cfg_rows - DIM_ONE);
        seq_len  = elem_len + (last_col ? 4'd2 : 4'd1);
        pos      = elem_len - 4'd1 - char_idx;
    end

    // Character selected by char_idx: element digits MSB first, then separator or CR LF
    always_comb begin
        nibble   = '0;
        byte_sel = '0;
        cur_char = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (pos == 4'(i)) begin
                nibble = elem_reg[i*4 +: 4];
            end
        end
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (pos == 4'(i)) begin
                byte_sel = elem_reg[i*8 +: 8];
            end
        end
        if (char_idx < elem_len) begin
            if (cfg_hex) begin
                cur_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                            : (8'h37 + {4'h0, nibble});
            end else begin
                cur_char = byte_sel;
            end
        end else if (!last_col) begin
            cur_char = SEP_CHAR;
        end else if (char_idx == elem_len) begin
            cur_char = 8'h0D;
        end else begin
            cur_char = 8'h0A;
        end
    end

    // Frame sequencer with registered handshake and status outputs
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cfg_hex     <= 1'b0;
            cfg_rows    <= '0;
            cfg_cols    <= '0;
            row_idx     <= '0;
            col_idx     <= '0;
            char_idx    <= '0;
            elem_reg    <= '0;
            data_req    <= 1'b0;
            start_uart  <= 1'b0;
            urt_tx_data <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            elem_count  <= '0;
        end else if (clock_enable) begin
            done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                start_uart <= 1'b0;
                data_req   <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            elem_count <= '0;
                            row_idx    <= '0;
                            col_idx    <= '0;
                            char_idx   <= '0;
                            if (num_rows == '0 || num_cols == '0) begin
                                done <= 1'b1;
                            end else begin
                                cfg_hex  <= mode_hex;
                                cfg_rows <= num_rows;
                                cfg_cols <= num_cols;
                                busy     <= 1'b1;
                                data_req <= 1'b1;
                                state    <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        if (data_req && data_valid) begin
                            elem_reg   <= data_in;
                            elem_count <= elem_count + COUNT_ONE;
                            data_req   <= 1'b0;
                            state      <= LOAD;
                        end
                    end
                    LOAD: begin
                        urt_tx_data <= cur_char;
                        start_uart  <= 1'b1;
                        state       <= KICK;
                    end
                    KICK: begin
                        start_uart <= 1'b0;
                        state      <= WAIT_TX;
                    end
                    WAIT_TX: begin
                        if (!busy_uart) begin
                            state <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (char_idx + 4'd1 < seq_len) begin
                            char_idx <= char_idx + 4'd1;
                            state    <= LOAD;
                        end else begin
                            char_idx <= '0;
                            if (last_row && last_col) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                if (last_col) begin
                                    col_idx <= '0;
                                    row_idx <= row_idx + DIM_ONE;
                                end else begin
                                    col_idx <= col_idx + DIM_ONE;
                                end
                                data_req <= 1'b1;
                                state    <= FETCH;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_matrix_formatter.md
UART_MATRIX_FORMATTER -- requirements
Module: uart_matrix_formatter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width; legal values 8, 16, 24, 32.
REQ-002 SHALL have parameter DIM_W, default 8, width of the row and column count inputs.
REQ-003 SHALL have parameter SEP_CHAR, default 8'h20, separator character between elements.
REQ-004 system_clock  in  1  clock; all registers on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 clock_enable  in  1  state, counters and outputs advance only on edges where this is high.
REQ-007 start  in  1  begin a frame; sampled in IDLE.
REQ-008 abort  in  1  terminate the frame.
REQ-009 mode_hex  in  1  1 = ASCII hex, 0 = raw bytes; latched at start.
REQ-010 num_rows  in  DIM_W  row count; latched at start.
REQ-011 num_cols  in  DIM_W  column count; latched at start.
REQ-012 data_in  in  DATA_W  element from source; data_valid  in  1  data_in valid.
REQ-013 data_req  out  1  element request; captured when data_req && data_valid on an enabled edge.
REQ-014 busy_uart  in  1  UART busy; start_uart  out  1  send-char pulse; urt_tx_data  out  8  character.
REQ-015 busy  out  1  frame in progress; done  out  1  frame-complete pulse; elem_count  out  2*DIM_W  elements captured.

Function
REQ-016 States SHALL be IDLE, FETCH, LOAD, KICK, WAIT_TX, NEXT.
REQ-017 IDLE->FETCH on start; config latched; elem_count, row/col/char indices cleared; busy=1. If either dimension is 0: IDLE->IDLE, done pulse, no characters sent.
REQ-018 FETCH: data_req=1; on capture, element registered, elem_count+1, data_req=0 on the next enabled edge, ->LOAD.
REQ-019 Per-element character sequence: hex mode sends DATA_W/4 nibbles, MSB first, as uppercase ASCII '0'-'9', 'A'-'F'; raw mode sends DATA_W/8 bytes, MSB first.
REQ-020 The element is followed by SEP_CHAR if it is not the last column, else by 0x0D then 0x0A.
REQ-021 LOAD: urt_tx_data = current character, ->KICK. KICK: start_uart=1 for exactly one enabled cycle, ->WAIT_TX.
REQ-022 WAIT_TX: start_uart=0; leaves on an enabled edge with busy_uart==0; the connected UART SHALL raise busy_uart on the edge after the start_uart edge.
REQ-023 urt_tx_data SHALL be stable from LOAD through WAIT_TX exit.
REQ-024 NEXT routing:
- more characters in this element/suffix -> LOAD;
- else more elements -> FETCH, with col wrapping at num_cols-1 to 0 and row+1;
- else -> IDLE with done=1 and busy=0.
REQ-025 done SHALL be high for exactly one enabled cycle and never asserted together with start_uart.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort (priority over all transitions) -> IDLE on the next enabled edge; start_uart=0, data_req=0, busy=0, no done; an in-flight UART character completes on its own.
REQ-028 elem_count holds its final value in IDLE until the next start.
REQ-029 Total characters per frame SHALL equal rows*cols*(N+1) + rows, where N = DATA_W/4 (hex) or DATA_W/8 (raw).
REQ-030 When clock_enable is low, all registers including done SHALL hold.

Reset
REQ-031 On rst_n low: state=IDLE, start_uart=0, data_req=0, busy=0, done=0, urt_tx_data=8'h00, elem_count=0, indices=0; this applies immediately, including mid-frame.
REQ-032 After rst_n deasserts, no character is sent until a new start.

Verification
REQ-033 DATA_W=8, hex, 2x2, data 0x1F,0xA0,0x05,0xFF, instant UART -> "1F A0\r\n05 FF\r\n" (14 chars), done once, elem_count=4.
REQ-034 DATA_W=16, raw, 1x3, data 0x1234,0x5678,0x9ABC -> 12,34,20,56,78,20,9A,BC,0D,0A.
REQ-035 num_cols=0 start -> done pulse within 2 enabled cycles, zero start_uart pulses.
REQ-036 abort during WAIT_TX of the 3rd character -> IDLE next enabled edge, no done, no further start_uart; a new start then begins cleanly.
REQ-037 clock_enable at 1-in-4 duty with busy_uart held 10 cycles per char and data_valid delayed 5 cycles -> output stream identical to REQ-033.
REQ-038 rst_n pulsed mid-frame -> all outputs at reset values the same cycle; start ignored while rst_n is low.
